alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_INIT, default 0, index of the port holding round-robin priority after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  port N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  port N operation accepted this cycle when high with reqN_valid.
REQ-006 reqN_a, reqN_b  input  32 each  port N operands.
REQ-007 reqN_op  input  3  port N ALU op code (AND/OR/ADD/SUB/SLT shared macro codes).
REQ-008 rspN_valid  output  1  port N result held in its response slot.
REQ-009 rspN_ready  input  1  port N consumes the result this cycle.
REQ-010 rspN_data  output  32  port N result word.
REQ-011 rspN_cmp  output  3  port N compare flags {A<B, A==B, A>B}, unsigned.
REQ-012 rspN_err  output  1  port N op code was undefined.
REQ-013 alu_a, alu_b  output  32 each  operands to the shared ALU.
REQ-014 alu_ctrl  output  3  op code to the shared ALU.
REQ-015 alu_data  input  32  combinational ALU result.
REQ-016 alu_cmp  input  3  combinational ALU compare flags.

Function
REQ-017 Port N SHALL be eligible when reqN_valid=1 and (rspN_valid=0 or rspN_ready=1).
REQ-018 At most one port SHALL be granted per cycle; a sole eligible port SHALL be granted; when both are eligible, the priority port SHALL be granted.
REQ-019 After any grant, priority SHALL move to the non-granted port; with no grant, priority SHALL be unchanged.
REQ-020 reqN_ready SHALL equal the grant for port N; it may depend combinationally on reqN_valid and rspN_ready.
REQ-021 With a grant, alu_a/alu_b/alu_ctrl SHALL carry the granted port's operands/op in the same cycle; with no grant or an undefined op, they SHALL be 0/0/ADD.
REQ-022 On a granted defined op, rspN_data/rspN_cmp SHALL load alu_data/alu_cmp at that edge, rspN_err SHALL load 0, rspN_valid SHALL be 1 from the next cycle (latency 1).
REQ-023 On a granted undefined op (codes other than AND/OR/ADD/SUB/SLT), the slot SHALL load data 0, cmp 3'b000, err 1, valid 1; the grant SHALL still count for round-robin.
REQ-024 While rspN_valid=1 and rspN_ready=0, rspN_data/cmp/err SHALL hold stable.
REQ-025 rspN_valid=1, rspN_ready=1 with no new grant SHALL clear rspN_valid at the edge; simultaneous consume and new grant SHALL keep rspN_valid=1 with the new result (back-to-back, one op per cycle per port).
REQ-026 A port whose slot is full and not being consumed SHALL not block the other port.

Reset
REQ-027 With reset=1 at an edge: rspN_valid=0, rspN_data=0, rspN_cmp=0, rspN_err=0, priority=RR_INIT.
REQ-028 While reset=1, reqN_ready SHALL be 0 and the ALU outputs SHALL be 0/0/ADD; any held or in-flight result SHALL be discarded.

Structure
REQ-029 Op codes SHALL come from the shared macro.v include; no local redefinition; the compare-flag bit order SHALL be defined there as well.
REQ-030 The one-entry response slot (valid/data/cmp/err with load and consume) SHALL be a sub-module alu_rsp_slot, instantiated once per port.
REQ-031 The shared ALU SHALL be instantiated outside this block and connected through the alu_* ports.

Verification
REQ-032 Reset, then req0 ADD 5,3 alone, rsp0_ready=1 -> req0_ready=1 at cycle 0; rsp0 at cycle 1: data 8, cmp 3'b001, err 0.
REQ-033 Both ports valid every cycle, RR_INIT=0, rsp ready tied 1 -> grants alternate 0,1,0,1; each port one result per two cycles.
REQ-034 req1 SUB 2,7, rsp1_ready=0 for 4 cycles -> rsp1 holds data 32'hFFFFFFFB, cmp 3'b100 stable; further req1 stalled; req0 traffic still served.
REQ-035 req0 op 3'b111 -> rsp0 data 0, cmp 0, err 1; priority passes to port 1.
REQ-036 req0 SLT 1,2 accepted, reset asserted next cycle before consume -> rsp0_valid=0 after reset, priority=RR_INIT, no stale result after release.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Types and constants for the two-port shared-ALU arbiter, bound to the shared macro codes.
package alu_arbiter_pkg;
`include "macro.v"

  localparam logic [2:0] OP_AND = `ALU_OP_AND;
  localparam logic [2:0] OP_OR  = `ALU_OP_OR;
  localparam logic [2:0] OP_ADD = `ALU_OP_ADD;
  localparam logic [2:0] OP_SUB = `ALU_OP_SUB;
  localparam logic [2:0] OP_SLT = `ALU_OP_SLT;
  localparam int CMP_LT = `ALU_CMP_LT;
  localparam int CMP_EQ = `ALU_CMP_EQ;
  localparam int CMP_GT = `ALU_CMP_GT;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } alu_req_t;

  function automatic logic op_defined(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction
endpackage

// File: rtl/alu_arbiter_rsp_slot.sv
// One-entry response slot: load wins over consume, contents hold while valid and unconsumed.
module alu_rsp_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        consume,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_cmp,
  input  logic        load_err,
  output logic        valid,
  output logic [31:0] data,
  output logic [2:0]  cmp,
  output logic        err
);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      cmp   <= '0;
      err   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      cmp   <= load_cmp;
      err   <= load_err;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/macro.v
// Shared ALU op codes and compare-flag bit positions used by every ALU client.
`ifndef ALU_MACRO_V
`define ALU_MACRO_V
`define ALU_OP_AND 3'b000
`define ALU_OP_OR  3'b001
`define ALU_OP_ADD 3'b010
`define ALU_OP_SUB 3'b011
`define ALU_OP_SLT 3'b100
`define ALU_CMP_LT 2
`define ALU_CMP_EQ 1
`define ALU_CMP_GT 0
`endif

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two request ports;
// results land in a per-port one-entry slot one cycle after the grant.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int RR_INIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic [2:0]  rsp0_cmp,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic [2:0]  rsp1_cmp,
  output logic        rsp1_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_data,
  input  logic [2:0]  alu_cmp
);
  logic        prio;
  logic        elig0, elig1, grant0, grant1;
  logic        undef;
  alu_req_t    sel;
  logic [31:0] load_data;
  logic [2:0]  load_cmp;

  always_comb begin
    // A full slot is eligible again when it is drained in the same cycle.
    elig0  = !reset && req0_valid && (!rsp0_valid || rsp0_ready);
    elig1  = !reset && req1_valid && (!rsp1_valid || rsp1_ready);
    grant0 = elig0 && (!elig1 || !prio);
    grant1 = elig1 && (!elig0 || prio);

    sel    = '0;
    sel.op = OP_ADD;
    undef  = 1'b0;
    if (grant0) begin
      sel = '{a: req0_a, b: req0_b, op: req0_op};
    end else if (grant1) begin
      sel = '{a: req1_a, b: req1_b, op: req1_op};
    end
    if (!op_defined(sel.op)) begin
      undef  = 1'b1;
      sel    = '0;
      sel.op = OP_ADD;
    end

    alu_a     = sel.a;
    alu_b     = sel.b;
    alu_ctrl  = sel.op;
    load_data = undef ? 32'd0 : alu_data;
    load_cmp  = undef ? 3'd0 : alu_cmp;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'(RR_INIT);
    end else if (grant0) begin
      prio <= 1'b1;
    end else if (grant1) begin
      prio <= 1'b0;
    end
  end

  alu_rsp_slot u_slot0 (
    .clk      (clk),
    .reset    (reset),
    .load     (grant0),
    .consume  (rsp0_ready),
    .load_data(load_data),
    .load_cmp (load_cmp),
    .load_err (undef),
    .valid    (rsp0_valid),
    .data     (rsp0_data),
    .cmp      (rsp0_cmp),
    .err      (rsp0_err)
  );

  alu_rsp_slot u_slot1 (
    .clk      (clk),
    .reset    (reset),
    .load     (grant1),
    .consume  (rsp1_ready),
    .load_data(load_data),
    .load_cmp (load_cmp),
    .load_err (undef),
    .valid    (rsp1_valid),
    .data     (rsp1_data),
    .cmp      (rsp1_cmp),
    .err      (rsp1_err)
  );
endmodule
